// File: rtl/mem_req_arbiter_pkg.sv
// Shared constants for the instruction/data memory request arbiter.
// Owner tags identify which requester issued an accepted request.
package mem_arb_pkg;
   localparam int OWN_W               = 1;
   localparam int MAX_OUTSTANDING_DEF = 4;

   typedef logic [OWN_W-1:0] owner_t;

   localparam owner_t OWN_INST = 1'b0;
   localparam owner_t OWN_DATA = 1'b1;
endpackage

// File: rtl/mem_req_arbiter_if.sv
// SRAM-like request/response port (req/addr_ok/data_ok).
// master drives the request fields; slave answers with addr_ok/data_ok/rdata.
interface mem_req_arbiter_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        uncached;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, addr, wdata, uncached,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wdata, uncached,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/mem_req_arbiter_owner_fifo.sv
// Circular FIFO of owner tags, one entry per accepted request.
// A push while full is dropped and a pop while empty is ignored.
module mem_arb_owner_fifo
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = MAX_OUTSTANDING_DEF,
   parameter int W     = OWN_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [W-1:0]             data_i,
   input  logic                     pop_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [W-1:0]             head_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Pointer and occupancy next state; pointers wrap naturally (power-of-two depth)
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer/count registers, cleared by reset so stale entries are discarded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Tag storage; contents are only meaningful below the count
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end
endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like memory port between the instruction and data requesters.
// Grant is held (locked) until the address is accepted; responses are routed
// back in acceptance order using the owner FIFO.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: round-robin between two pending
// requesters instead of fixed data-over-inst priority.
module mem_req_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
   input  logic              aclk,
   input  logic              aresetn,
   mem_req_arbiter_if.slave  inst,
   mem_req_arbiter_if.slave  data,
   mem_req_arbiter_if.master mem,
   output logic              busy
);
   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

   owner_t        grant;
   owner_t        head_owner;
   owner_t        lock_owner_q, lock_owner_d;
   logic          lock_valid_q, lock_valid_d;
   logic          grant_data;
   logic          grant_req;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          mem_req_w;
   logic          accept;
   logic          resp;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   owner_t rr_last_q, rr_last_d;

   // Remember who won the most recent accept
   always_comb rr_last_d = accept ? grant : rr_last_q;

   // Round-robin history register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) rr_last_q <= OWN_INST;
      else          rr_last_q <= rr_last_d;
   end

   // Grant: held owner first, otherwise alternate when both are pending
   always_comb begin
      grant = OWN_INST;
      if (lock_valid_q)            grant = lock_owner_q;
      else if (data.req & inst.req) grant = (rr_last_q == OWN_DATA) ? OWN_INST : OWN_DATA;
      else if (data.req)            grant = OWN_DATA;
   end
`else
   // Grant: held owner first, otherwise data wins over inst
   always_comb begin
      grant = OWN_INST;
      if (lock_valid_q)  grant = lock_owner_q;
      else if (data.req) grant = OWN_DATA;
   end
`endif

   assign grant_data = (grant == OWN_DATA);
   assign grant_req  = grant_data ? data.req : inst.req;
   assign mem_req_w  = aresetn & grant_req & ~fifo_full;
   assign accept     = mem_req_w & mem.addr_ok;
   assign resp       = aresetn & mem.data_ok & ~fifo_empty;

   // Downstream request: combinational mux of the granted requester
   assign mem.req      = mem_req_w;
   assign mem.wr       = aresetn & (grant_data ? data.wr : inst.wr);
   assign mem.size     = aresetn ? (grant_data ? data.size  : inst.size)  : 2'b00;
   assign mem.addr     = aresetn ? (grant_data ? data.addr  : inst.addr)  : 32'h0;
   assign mem.wdata    = aresetn ? (grant_data ? data.wdata : inst.wdata) : 32'h0;
   assign mem.uncached = aresetn & (grant_data ? data.uncached : inst.uncached);

   // Upstream handshakes and read data
   assign inst.addr_ok = accept & ~grant_data;
   assign data.addr_ok = accept & grant_data;
   assign inst.data_ok = resp & (head_owner == OWN_INST);
   assign data.data_ok = resp & (head_owner == OWN_DATA);
   assign inst.rdata   = aresetn ? mem.rdata : 32'h0;
   assign data.rdata   = aresetn ? mem.rdata : 32'h0;
   assign busy         = aresetn & ((fifo_count != '0) | lock_valid_q);

   // Lock the grant while a presented request waits for addr_ok
   always_comb begin
      lock_valid_d = lock_valid_q;
      lock_owner_d = lock_owner_q;
      if (accept) begin
         lock_valid_d = 1'b0;
      end else if (mem_req_w) begin
         lock_valid_d = 1'b1;
         lock_owner_d = grant;
      end
   end

   // Lock registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         lock_valid_q <= 1'b0;
         lock_owner_q <= OWN_INST;
      end else begin
         lock_valid_q <= lock_valid_d;
         lock_owner_q <= lock_owner_d;
      end
   end

   mem_arb_owner_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .W     (OWN_W)
   ) u_owner_fifo (
      .clk     (aclk),
      .rst_n   (aresetn),
      .push_i  (accept),
      .data_i  (grant),
      .pop_i   (resp),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head_owner),
      .count_o (fifo_count)
   );
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one SRAM-like (req/addr_ok/data_ok) memory port between the CPU instruction and data requesters.
- Sits between the core's inst_*/data_* ports and a single downstream bridge/cache port.
- Arbitrates requests, keeps each grant stable until the address is accepted, and records the owner of every accepted request in an in-order FIFO.
- Routes each data_ok/rdata back to the requester that issued it; supports up to MAX_OUTSTANDING in-flight transactions.

Parameters:
MAX_OUTSTANDING, 4, depth of owner FIFO; power of two, 2..16
OWN_W, 1, owner tag width (0 = inst, 1 = data)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
inst_req  in  1  instruction request valid
inst_wr  in  1  write
inst_size  in  2  access size
inst_addr  in  32  address
inst_wdata  in  32  write data
inst_uncached  in  1  uncached attribute
inst_addr_ok  out  1  request accepted
inst_data_ok  out  1  response valid
inst_rdata  out  32  read data
data_req, data_wr, data_size, data_addr, data_wdata, data_uncached  in  1/1/2/32/32/1  data requester, same meaning as inst_*
data_addr_ok  out  1  request accepted
data_data_ok  out  1  response valid
data_rdata  out  32  read data
mem_req  out  1  downstream request valid
mem_wr, mem_size, mem_addr, mem_wdata, mem_uncached  out  1/2/32/32/1  forwarded fields of the granted requester
mem_addr_ok  in  1  downstream accepted request
mem_data_ok  in  1  downstream response valid
mem_rdata  in  32  downstream read data
busy  out  1  FIFO non-empty or lock held

Behaviour:
- Reset (aresetn=0, async): FIFO empty, pointers/count=0, lock_valid=0, rr_last=inst. All handshake outputs are 0 while in reset; mem_* fields are 0.
- Grant: if lock_valid, grant=lock_owner. Otherwise fixed priority: data over inst.
- mem_req = granted requester's req & ~fifo_full. mem_* fields are a combinational mux of the granted requester; zero added latency.
- Lock: if mem_req=1 and mem_addr_ok=0 at a clock edge, set lock_valid=1 and lock_owner=grant. Clear the lock on the accepting edge. The request fields stay stable while they wait.
- Accept: mem_req & mem_addr_ok. In the same cycle, raise <grant>_addr_ok=1; the other requester's addr_ok stays 0. At the edge, push the owner into the FIFO.
- Full: when count==MAX_OUTSTANDING, mem_req=0 and both addr_ok=0, even if mem_data_ok pops in that cycle. No push-through when full.
- Response: on mem_data_ok with FIFO non-empty, raise <head owner>_data_ok=1 in the same cycle and drive that requester's rdata=mem_rdata. Pop at the edge.
- Rdata: inst_rdata and data_rdata both carry mem_rdata unconditionally; only data_ok qualifies them.
- Simultaneous push and pop with the FIFO not full: count is unchanged and both pointers advance, wrapping modulo MAX_OUTSTANDING.
- Spurious mem_data_ok while empty: ignored; no pop, no data_ok.
- Ordering: responses return strictly in acceptance order; the downstream port is required to be in-order.
- Reset mid-transaction: outstanding state is discarded. Downstream responses arriving after reset are treated as spurious.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both requesters are pending and no lock is held, grant the requester that was not granted last (rr_last). rr_last updates on each accept.
- Undefined: fixed data-over-inst priority and no rr_last register.

Decomposition:
- Package mem_arb_pkg: OWN_INST=1'b0, OWN_DATA=1'b1, OWN_W, and the default MAX_OUTSTANDING.
- Sub-module mem_arb_owner_fifo: synchronous circular FIFO of owner tags with push, pop, full, empty, head and count.

Test Plan:
- inst_req only at 0x1FC00000, mem_addr_ok=1 in the same cycle, mem_data_ok 3 cycles later with rdata=0x3C080001 -> inst_addr_ok=1 that cycle; inst_data_ok=1 and inst_rdata=0x3C080001 three cycles later; data_* stay 0.
- inst_req and data_req both asserted, mem_addr_ok=1 each cycle -> data accepted first, inst next cycle; responses arrive in FIFO order with data_ok then inst_ok. With MEM_ARB_ROUND_ROBIN_EN defined, an inst-first sequence alternates.
- data_req to addr 0x80000010, mem_addr_ok held low 4 cycles, inst_req raised in cycle 2 -> mem_addr stays 0x80000010 throughout; data_addr_ok pulses on the 5th cycle.
- Four accepts with no mem_data_ok -> count=4; a 5th request sees mem_req=0 and addr_ok=0. One mem_data_ok frees a slot; the next cycle's accept succeeds.
- mem_data_ok pulse with the FIFO empty -> no data_ok, count stays 0. aresetn dropped with 2 outstanding -> busy=0, all outputs 0 asynchronously.
